// File: rtl/demux12_16_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_pkg : shared types for the buffered 1:2 16-bit demultiplexer |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
package demux_pkg;
  localparam int WIDTH = 16;

  typedef logic [15:0] word_t;

  // Same select polarity as the 2:1 operand mux
  typedef enum logic {
    DEST_B = 1'b0,
    DEST_A = 1'b1
  } dest_e;
endpackage
`default_nettype wire

// File: rtl/demux12_16_buf_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : circular-buffer FIFO with wrap-bit full/empty flags    |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/demux12_16_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux12_16_buf : buffered 1:2 demux, one FIFO per destination      |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module demux12_16_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);
  import demux_pkg::*;

  dest_e            sel_dest;
  logic             a_full, a_empty, b_full, b_empty;
  logic             a_push, b_push, a_pop, b_pop;
  logic [CNT_W-1:0] a_count_q, a_count_d;
  logic [CNT_W-1:0] b_count_q, b_count_d;

  assign sel_dest = dest_e'(in_sel);

  // Registered full flags only, so downstream ready never reaches in_ready
  assign in_ready = !rst && ((sel_dest == DEST_A) ? !a_full : !b_full);

  assign a_push  = in_valid && in_ready && (sel_dest == DEST_A);
  assign b_push  = in_valid && in_ready && (sel_dest == DEST_B);
  assign a_valid = !a_empty;
  assign b_valid = !b_empty;
  assign a_pop   = a_valid && a_ready;
  assign b_pop   = b_valid && b_ready;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_push),
    .din   (in_data),
    .pop   (a_pop),
    .dout  (a_data),
    .full  (a_full),
    .empty (a_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .din   (in_data),
    .pop   (b_pop),
    .dout  (b_data),
    .full  (b_full),
    .empty (b_empty)
  );

  always_comb begin
    a_count_d = a_count_q + CNT_W'(a_pop);
    b_count_d = b_count_q + CNT_W'(b_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
endmodule
`default_nettype wire

// File: tb/tb_demux12_16_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_demux12_16_buf : directed steps with a per-destination scoreboard|
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module tb_demux12_16_buf;
  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [15:0] a_count, b_count;

  logic        in_ready4;
  logic [15:0] a_data4, b_data4;
  logic        a_valid4, b_valid4;
  logic [3:0]  a_count4, b_count4;

  int n_cmp = 0;
  int n_err = 0;
  int ea    = 0;
  int eb    = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  demux12_16_buf #(.WIDTH(16), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  // Narrow-counter copy driven by the same stimulus, used for wrap checks
  demux12_16_buf #(.WIDTH(16), .DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready4), .a_data(a_data4), .a_valid(a_valid4), .a_ready(a_ready),
    .b_data(b_data4), .b_valid(b_valid4), .b_ready(b_ready),
    .a_count(a_count4), .b_count(b_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pops/compares before pushes, since a word can never bypass
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
      qa.delete();
      qb.delete();
      ea = 0;
      eb = 0;
    end else begin
      chk("a_count", {16'd0, a_count}, ea & 32'hFFFF);
      chk("b_count", {16'd0, b_count}, eb & 32'hFFFF);
      chk("a_count4", {28'd0, a_count4}, ea & 32'hF);
      chk("b_count4", {28'd0, b_count4}, eb & 32'hF);
      chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
      chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
      chk("in_ready", {31'd0, in_ready},
          {31'd0, in_sel ? (qa.size() < 2) : (qb.size() < 2)});
      if (a_valid && a_ready && qa.size() != 0) begin
        chk("a_data_order", {16'd0, a_data}, {16'd0, qa.pop_front()});
        ea++;
      end
      if (b_valid && b_ready && qb.size() != 0) begin
        chk("b_data_order", {16'd0, b_data}, {16'd0, qb.pop_front()});
        eb++;
      end
      if (in_valid && in_ready) begin
        if (in_sel) qa.push_back(in_data);
        else        qb.push_back(in_data);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic s);
    int n = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout observed=stalled expected=accept data=%0h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_a_data", {16'd0, a_data}, 32'd0);
    chk("rst_b_data", {16'd0, b_data}, 32'd0);
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);

    // Single word to A
    tick();
    a_ready = 1'b1; b_ready = 1'b1;
    send(16'h1234, 1'b1);
    @(negedge clk);
    chk("single_a_valid", {31'd0, a_valid}, 32'd1);
    chk("single_a_data", {16'd0, a_data}, 32'h1234);
    chk("single_b_valid", {31'd0, b_valid}, 32'd0);
    @(negedge clk);
    chk("single_a_count", {16'd0, a_count}, 32'd1);

    // Fill A while it is stalled; B still flows
    tick();
    a_ready = 1'b0; b_ready = 1'b1;
    send(16'h0001, 1'b1);
    send(16'h0002, 1'b1);
    in_data = 16'h0003; in_sel = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("full_a_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("full_a_in_ready2", {31'd0, in_ready}, 32'd0);
    chk("full_a_head", {16'd0, a_data}, 32'h0001);
    tick();
    send(16'hBEEF, 1'b0);
    @(negedge clk);
    chk("beef_b_valid", {31'd0, b_valid}, 32'd1);
    chk("beef_b_data", {16'd0, b_data}, 32'hBEEF);
    chk("beef_a_head", {16'd0, a_data}, 32'h0001);

    // Pop on full in the same cycle as a push attempt
    tick();
    in_data = 16'h0003; in_sel = 1'b1; in_valid = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    chk("popfull_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("popfull_in_ready_next", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();

    // Streaming, alternating destinations
    for (int i = 0; i < 100; i++) begin
      in_data  = 16'(i);
      in_sel   = (i % 2 == 0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("stream_a_count", {16'd0, a_count}, 32'd54);
    chk("stream_b_count", {16'd0, b_count}, 32'd51);
    chk("stream_a_count4", {28'd0, a_count4}, 32'd6);
    chk("stream_b_count4", {28'd0, b_count4}, 32'd3);

    // Reset with both FIFOs holding two words
    tick();
    a_ready = 1'b0; b_ready = 1'b0;
    send(16'h0011, 1'b1);
    send(16'h0012, 1'b1);
    send(16'h0021, 1'b0);
    send(16'h0022, 1'b0);
    @(negedge clk);
    chk("pre_rst_a_valid", {31'd0, a_valid}, 32'd1);
    chk("pre_rst_b_valid", {31'd0, b_valid}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("post_rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("post_rst_a_count", {16'd0, a_count}, 32'd0);
    chk("post_rst_b_count", {16'd0, b_count}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    a_ready = 1'b1; b_ready = 1'b1;
    send(16'h5A5A, 1'b1);
    @(negedge clk);
    chk("post_rst_route_valid", {31'd0, a_valid}, 32'd1);
    chk("post_rst_route_data", {16'd0, a_data}, 32'h5A5A);
    @(negedge clk);
    chk("post_rst_route_count", {16'd0, a_count}, 32'd1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
